cpu_mem_responder: RTL
======================

# cpu_mem_responder

Memory-side responder for the CPU core's instruction and data ports. It owns a single word-organised RAM shared by two request ports. The instruction port is read-only. The data port is read/write with per-byte write enables. Each port accepts one request at a time, waits a configurable number of cycles, and returns a single-cycle response pulse. It sits between the CPU core and the on-chip memory, acting as the target of the core's fetch and load/store traffic.

## Interface
Parameters:
- DEPTH, 1024: RAM size in 32-bit words; power of two, 16..65536.
- WAIT_STATES, 0: extra cycles inserted before each response; range 0..15, same for both ports.
- INIT_FILE, "": hex file loaded into the RAM at elaboration via $readmemh. An empty string leaves the RAM contents uninitialised.

Ports:
- aclk, input, 1: the single clock; all logic rises on its positive edge.
- areset, input, 1: asynchronous active-high reset.
- inst_addr, input, 32: instruction byte address. Bits [1:0] are ignored.
- inst_en, input, 1: instruction read request.
- inst_ready, output, 1: instruction port idle; a request is accepted when inst_en and inst_ready are both high.
- inst_rdata, output, 32: fetched word. It is valid when inst_rvalid is high and holds its value until the next response.
- inst_rvalid, output, 1: one-cycle response pulse for the instruction port.
- data_addr, input, 32: data byte address. Bits [1:0] are ignored.
- data_wdata, input, 32: store data; byte lane i is bits [8i+7:8i].
- data_en, input, 1: data request.
- data_we, input, 4: byte write enables. A value of 0 means a read.
- data_ready, output, 1: data port idle.
- data_rdata, output, 32: read data. For a write, this is the word contents before the write.
- data_rvalid, output, 1: one-cycle response pulse for the data port.
- data_err, output, 1: out-of-range flag, asserted together with data_rvalid. It exists only when MEM_BOUNDS_CHECK_EN is defined.

## Operation
- Each port has its own FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: ready=1. On the accept edge, the port captures address, we and wdata into its request registers. It goes to WAIT if WAIT_STATES>0, otherwise straight to RESP.
  - WAIT: a 4-bit counter loads WAIT_STATES-1 and decrements. The port moves to RESP on the edge where the counter is 0.
  - RESP: the memory access is performed on the edge entering RESP. rvalid=1 for exactly one cycle, then the port returns to IDLE. ready=0 while in RESP.
- Word index = captured address [log2(DEPTH)+1:2].
- Read-first semantics:
  - rdata is the word as it was before any write on the same edge.
  - A write updates only the lanes with we[i]=1.
- Port collision: the instruction read and data write may hit the same word on the same edge. The instruction port then returns the old word, and the write still commits.
- Request inputs are ignored while a port is not IDLE. No buffering is performed; inputs are not required to be held after acceptance.
- The two ports are fully independent; there is no arbitration.

## Timing
- Latency from the accept edge to the rvalid cycle is 1+WAIT_STATES cycles.
- Throughput is one request per 2+WAIT_STATES cycles per port, because the RESP cycle blocks acceptance.
- Reset values:
  - inst_ready=1 and data_ready=1.
  - inst_rvalid, data_rvalid and data_err are 0.
  - inst_rdata and data_rdata are 0.
  - Both FSMs are in IDLE with counters at 0.
- Reset mid-operation: pending requests are discarded and no write commits. RAM contents are retained. rvalid never asserts for an aborted request.
- rdata and data_err are registered; they change only on the response edge or on reset.

## Configuration
- MEM_BOUNDS_CHECK_EN, defined: a data request is out of range if data_addr[31:log2(DEPTH)+2] is non-zero. In that case:
  - the write is dropped;
  - data_rdata=32'hDEAD_BEEF;
  - data_err=1 during the rvalid cycle.

  The instruction port does not check bounds; it wraps.
- MEM_BOUNDS_CHECK_EN, undefined: the data_err port is absent. The upper address bits are ignored and all addresses wrap modulo DEPTH words.

## Test plan
- Basic write/read, WAIT_STATES=0: write data_we=4'hF, data_addr=0x10, data_wdata=0x12345678 -> rvalid 1 cycle after accept, rdata = old word. Then read 0x10 -> data_rdata=0x12345678 one cycle after accept.
- Byte enables: word 0x20 = 0xAABBCCDD; write we=4'b0101, wdata=0x11223344 -> a subsequent read returns 0xAA22CC44.
- Wait states and backpressure, WAIT_STATES=3: accept a read -> rvalid exactly 4 cycles later. A data_en pulse during WAIT is ignored, and ready=0 for cycles 1..4 after accept.
- Collision: on the same cycle, write 0xCAFEF00D to word 5 and fetch inst_addr=0x14 (old value 0x00000013) -> inst_rdata=0x00000013. A later fetch returns 0xCAFEF00D.
- Reset mid-operation, WAIT_STATES=5: issue a write, then pulse areset 2 cycles later -> no rvalid, all outputs at reset values, word unchanged on readback.
- Bounds, DEPTH=1024, with MEM_BOUNDS_CHECK_EN defined: write to data_addr=0x1000 -> data_err=1, rdata=0xDEADBEEF, word 0 unchanged. With the macro undefined, the same write lands in word 0.

Source files
------------

// File: rtl/cpu_mem_responder_if.sv
// Instruction and data request/response bundle between the CPU core and cpu_mem_responder.
// data_err is present only when MEM_BOUNDS_CHECK_EN is defined.
`timescale 1ns/1ps
interface cpu_mem_responder_if;
  logic [31:0] inst_addr;
  logic        inst_en;
  logic        inst_ready;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_en;
  logic [3:0]  data_we;
  logic        data_ready;
  logic [31:0] data_rdata;
  logic        data_rvalid;
`ifdef MEM_BOUNDS_CHECK_EN
  logic        data_err;
`endif

  modport master (
    output inst_addr, inst_en,
    input  inst_ready, inst_rdata, inst_rvalid,
    output data_addr, data_wdata, data_en, data_we,
    input  data_ready, data_rdata, data_rvalid
`ifdef MEM_BOUNDS_CHECK_EN
    , input data_err
`endif
  );

  modport slave (
    input  inst_addr, inst_en,
    output inst_ready, inst_rdata, inst_rvalid,
    input  data_addr, data_wdata, data_en, data_we,
    output data_ready, data_rdata, data_rvalid
`ifdef MEM_BOUNDS_CHECK_EN
    , output data_err
`endif
  );
endinterface

// File: rtl/cpu_mem_responder.sv
// Two-port word RAM responder: read-only instruction port, byte-enabled data port, fixed wait states.
// Optional feature macro MEM_BOUNDS_CHECK_EN adds out-of-range detection on the data port.
`timescale 1ns/1ps
module cpu_mem_responder #(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic                aclk,
  input  logic                areset,
  cpu_mem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [31:0] mem_r [DEPTH];

  state_t          i_state_r, i_state_nx_s;
  logic [3:0]      i_cnt_r, i_cnt_nx_s;
  logic            i_go_s;
  logic [AW-1:0]   i_idx_r, i_idx_s;
  logic            i_ready_r, i_rvalid_r;
  logic [31:0]     i_rdata_r;

  state_t          d_state_r, d_state_nx_s;
  logic [3:0]      d_cnt_r, d_cnt_nx_s;
  logic            d_go_s;
  logic [AW-1:0]   d_idx_r, d_idx_s;
  logic [3:0]      d_we_r, d_we_s;
  logic [31:0]     d_wdata_r, d_wdata_s;
  logic            d_oor_s;
  logic            d_ready_r, d_rvalid_r;
  logic [31:0]     d_rdata_r;
  logic            unused_s;

  // In IDLE the access (WAIT_STATES=0) must use the live request, otherwise the captured one.
  assign i_idx_s   = (i_state_r == ST_IDLE) ? bus.inst_addr[AW+1:2] : i_idx_r;
  assign d_idx_s   = (d_state_r == ST_IDLE) ? bus.data_addr[AW+1:2] : d_idx_r;
  assign d_we_s    = (d_state_r == ST_IDLE) ? bus.data_we : d_we_r;
  assign d_wdata_s = (d_state_r == ST_IDLE) ? bus.data_wdata : d_wdata_r;

`ifdef MEM_BOUNDS_CHECK_EN
  logic d_oor_r;
  logic d_err_r;
  assign d_oor_s = (d_state_r == ST_IDLE) ? (|bus.data_addr[31:AW+2]) : d_oor_r;
  assign bus.data_err = d_err_r;
`else
  assign d_oor_s = 1'b0;
`endif

  assign unused_s = ^{bus.inst_addr[31:AW+2], bus.inst_addr[1:0],
                      bus.data_addr[31:AW+2], bus.data_addr[1:0]};

  // Instruction port next-state and wait counter.
  always_comb begin
    i_state_nx_s = i_state_r;
    i_cnt_nx_s   = i_cnt_r;
    i_go_s       = 1'b0;
    case (i_state_r)
      ST_IDLE: begin
        if (bus.inst_en) begin
          if (WAIT_STATES > 0) begin
            i_state_nx_s = ST_WAIT;
            i_cnt_nx_s   = WS_LOAD;
          end else begin
            i_state_nx_s = ST_RESP;
            i_go_s       = 1'b1;
          end
        end else begin
          i_state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (i_cnt_r == 4'd0) begin
          i_state_nx_s = ST_RESP;
          i_go_s       = 1'b1;
        end else begin
          i_cnt_nx_s = i_cnt_r - 4'd1;
        end
      end
      ST_RESP: i_state_nx_s = ST_IDLE;
      default: i_state_nx_s = ST_IDLE;
    endcase
  end

  // Data port next-state and wait counter.
  always_comb begin
    d_state_nx_s = d_state_r;
    d_cnt_nx_s   = d_cnt_r;
    d_go_s       = 1'b0;
    case (d_state_r)
      ST_IDLE: begin
        if (bus.data_en) begin
          if (WAIT_STATES > 0) begin
            d_state_nx_s = ST_WAIT;
            d_cnt_nx_s   = WS_LOAD;
          end else begin
            d_state_nx_s = ST_RESP;
            d_go_s       = 1'b1;
          end
        end else begin
          d_state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (d_cnt_r == 4'd0) begin
          d_state_nx_s = ST_RESP;
          d_go_s       = 1'b1;
        end else begin
          d_cnt_nx_s = d_cnt_r - 4'd1;
        end
      end
      ST_RESP: d_state_nx_s = ST_IDLE;
      default: d_state_nx_s = ST_IDLE;
    endcase
  end

  // Instruction port state, request capture and registered response.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      i_state_r  <= ST_IDLE;
      i_cnt_r    <= 4'd0;
      i_idx_r    <= '0;
      i_ready_r  <= 1'b1;
      i_rvalid_r <= 1'b0;
      i_rdata_r  <= 32'd0;
    end else begin
      i_state_r  <= i_state_nx_s;
      i_cnt_r    <= i_cnt_nx_s;
      i_ready_r  <= (i_state_nx_s == ST_IDLE);
      i_rvalid_r <= i_go_s;
      if (i_state_r == ST_IDLE && bus.inst_en) begin
        i_idx_r <= bus.inst_addr[AW+1:2];
      end
      if (i_go_s) begin
        i_rdata_r <= mem_r[i_idx_s];
      end
    end
  end

  // Data port state, request capture and registered response (read-first).
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      d_state_r  <= ST_IDLE;
      d_cnt_r    <= 4'd0;
      d_idx_r    <= '0;
      d_we_r     <= 4'd0;
      d_wdata_r  <= 32'd0;
      d_ready_r  <= 1'b1;
      d_rvalid_r <= 1'b0;
      d_rdata_r  <= 32'd0;
`ifdef MEM_BOUNDS_CHECK_EN
      d_oor_r    <= 1'b0;
      d_err_r    <= 1'b0;
`endif
    end else begin
      d_state_r  <= d_state_nx_s;
      d_cnt_r    <= d_cnt_nx_s;
      d_ready_r  <= (d_state_nx_s == ST_IDLE);
      d_rvalid_r <= d_go_s;
      if (d_state_r == ST_IDLE && bus.data_en) begin
        d_idx_r   <= bus.data_addr[AW+1:2];
        d_we_r    <= bus.data_we;
        d_wdata_r <= bus.data_wdata;
`ifdef MEM_BOUNDS_CHECK_EN
        d_oor_r   <= |bus.data_addr[31:AW+2];
`endif
      end
      if (d_go_s) begin
        d_rdata_r <= d_oor_s ? 32'hDEAD_BEEF : mem_r[d_idx_s];
`ifdef MEM_BOUNDS_CHECK_EN
        d_err_r   <= d_oor_s;
`endif
      end
    end
  end

  // RAM write; gated by areset so an edge coinciding with reset never commits.
  always_ff @(posedge aclk) begin
    if (d_go_s && !areset && !d_oor_s) begin
      for (int i = 0; i < 4; i++) begin
        if (d_we_s[i]) begin
          mem_r[d_idx_s][8*i +: 8] <= d_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.inst_ready  = i_ready_r;
  assign bus.inst_rvalid = i_rvalid_r;
  assign bus.inst_rdata  = i_rdata_r;
  assign bus.data_ready  = d_ready_r;
  assign bus.data_rvalid = d_rvalid_r;
  assign bus.data_rdata  = d_rdata_r;
endmodule
